// File: rtl/axis_pack_32to128.sv
// Packs a byte-granular IN_W AXI4-Stream into OUT_W beats (low-byte-contiguous tkeep),
// zero-filling unused bytes, flagging illegal tkeep and counting packets.
module axis_pack_32to128 #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 128
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [IN_W-1:0]    s_axis_tdata,
    input  logic [IN_W/8-1:0]  s_axis_tkeep,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [OUT_W-1:0]   m_axis_tdata,
    output logic [OUT_W/8-1:0] m_axis_tkeep,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               keep_err,
    output logic [31:0]        pkt_cnt
);
    localparam int RATIO = OUT_W / IN_W;
    localparam int KW    = IN_W / 8;
    localparam int CW    = $clog2(RATIO);

    logic [CW-1:0]                 word_cnt;
    logic [RATIO-2:0][IN_W-1:0]    acc;

    logic                          complete;
    logic                          accept;
    logic                          keep_all;
    logic                          keep_zero;
    logic                          keep_contig;
    logic                          empty_last;
    logic                          load;
    logic                          keep_err_nxt;
    logic [KW-1:0]                 cur_keep;
    logic [IN_W-1:0]               cur_data;
    logic [RATIO-1:0][IN_W-1:0]    slot_data;
    logic [RATIO-1:0][KW-1:0]      slot_keep;

    assign complete      = (word_cnt == CW'(RATIO - 1)) || s_axis_tlast;
    assign s_axis_tready = !complete || !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign keep_all    = (s_axis_tkeep == '1);
    assign keep_zero   = (s_axis_tkeep == '0);
    assign keep_contig = ((s_axis_tkeep & (s_axis_tkeep + KW'(1))) == '0);

    // An empty last word with nothing accumulated has no bytes to emit.
    assign empty_last = s_axis_tlast && keep_zero && (word_cnt == '0);
    assign load       = accept && complete && !empty_last;

    assign keep_err_nxt = accept && (s_axis_tlast ? (keep_zero ? (word_cnt == '0) : !keep_contig)
                                                  : !keep_all);

    // Only a last word may be short; earlier words always count as full.
    assign cur_keep = s_axis_tlast ? s_axis_tkeep : '1;

    always_comb begin
        cur_data = '0;
        for (int b = 0; b < KW; b++) begin
            cur_data[8*b +: 8] = cur_keep[b] ? s_axis_tdata[8*b +: 8] : 8'h00;
        end
    end

    for (genvar k = 0; k < RATIO; k++) begin : g_slot
        if (k < RATIO - 1) begin : g_acc
            assign slot_data[k] = (CW'(k) < word_cnt)  ? acc[k]   :
                                  (CW'(k) == word_cnt) ? cur_data : '0;
            assign slot_keep[k] = (CW'(k) < word_cnt)  ? '1       :
                                  (CW'(k) == word_cnt) ? cur_keep : '0;
        end else begin : g_top
            assign slot_data[k] = (CW'(k) == word_cnt) ? cur_data : '0;
            assign slot_keep[k] = (CW'(k) == word_cnt) ? cur_keep : '0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            word_cnt      <= '0;
            acc           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            keep_err      <= 1'b0;
            pkt_cnt       <= '0;
        end else begin
            keep_err <= keep_err_nxt;

            if (accept) begin
                if (complete) begin
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + CW'(1);
                    for (int k = 0; k < RATIO - 1; k++) begin
                        if (word_cnt == CW'(k)) acc[k] <= s_axis_tdata;
                    end
                end
            end

            if (load) begin
                m_axis_tdata  <= slot_data;
                m_axis_tkeep  <= slot_keep;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_pack_32to128.sv
// Scoreboard bench for axis_pack_32to128: expected beats are queued as words are
// driven and compared as the DUT hands them off.
module tb_axis_pack_32to128;

    logic         aclk = 1'b0;
    logic         areset;
    logic [31:0]  s_tdata;
    logic [3:0]   s_tkeep;
    logic         s_tlast;
    logic         s_tvalid;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic         keep_err;
    logic [31:0]  pkt_cnt;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    beat_t q[$];
    beat_t mon_e;
    int    n_cmp   = 0;
    int    n_err   = 0;
    int    err_seen = 0;
    int    exp_pkt = 0;
    int    cyc     = 0;

    axis_pack_32to128 dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .keep_err      (keep_err),
        .pkt_cnt       (pkt_cnt)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc++;

    always @(negedge aclk) begin
        if (!areset) begin
            if (keep_err) err_seen++;
            if (m_tvalid && m_tready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat got d=%h k=%h l=%b", m_tdata, m_tkeep, m_tlast);
                end else begin
                    mon_e = q.pop_front();
                    if ({m_tdata, m_tkeep, m_tlast} !== {mon_e.d, mon_e.k, mon_e.l}) begin
                        n_err++;
                        $display("FAIL beat got d=%h k=%h l=%b exp d=%h k=%h l=%b",
                                 m_tdata, m_tkeep, m_tlast, mon_e.d, mon_e.k, mon_e.l);
                    end
                end
            end
        end
    end

    task automatic expect_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        q.push_back(b);
        if (l) exp_pkt++;
    endtask

    // Entered and left #1 after a rising edge; the handshake is the edge in between.
    task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        int  b = 0;
        logic ok;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            ok = s_tready;
            b++;
        end while (!ok && b < 200);
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout s_tready=%b required 1", s_tready);
        end
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int b = 0;
        while ((q.size() != 0 || m_tvalid) && b < 500) begin
            @(negedge aclk);
            b++;
        end
        repeat (2) @(negedge aclk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain pending=%0d required 0", name, q.size());
        end
        n_cmp++;
        if (pkt_cnt !== 32'(exp_pkt)) begin
            n_err++;
            $display("FAIL %s_pkt_cnt got %0d required %0d", name, pkt_cnt, exp_pkt);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_reset;
        areset = 1'b1; m_tready = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        n_cmp++;
        if ({m_tvalid, m_tlast, keep_err} !== 3'b000) begin
            n_err++; $display("FAIL reset_flags got %b required 000", {m_tvalid, m_tlast, keep_err});
        end
        n_cmp++;
        if (m_tdata !== '0 || m_tkeep !== '0) begin
            n_err++; $display("FAIL reset_data got d=%h k=%h required 0", m_tdata, m_tkeep);
        end
        n_cmp++;
        if (pkt_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_pkt_cnt got %0d required 0", pkt_cnt);
        end
        n_cmp++;
        if (s_tready !== 1'b1) begin
            n_err++; $display("FAIL reset_s_tready got %b required 1", s_tready);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_full_block;
        expect_beat(128'hFFEEDDCC_BBAA9988_77665544_33221100, 16'hFFFF, 1'b1);
        send_word(32'h33221100, 4'hF, 1'b0);
        send_word(32'h77665544, 4'hF, 1'b0);
        send_word(32'hBBAA9988, 4'hF, 1'b0);
        n_cmp++;
        if (m_tvalid !== 1'b0) begin
            n_err++; $display("FAIL full_early_valid got %b required 0", m_tvalid);
        end
        send_word(32'hFFEEDDCC, 4'hF, 1'b1);
        @(negedge aclk);
        n_cmp++;
        if (m_tvalid !== 1'b1) begin
            n_err++; $display("FAIL full_latency m_tvalid got %b required 1", m_tvalid);
        end
        wait_drain("full");
    endtask

    task automatic test_short_block;
        expect_beat(128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, 1'b0);
        expect_beat(128'h00000000_00000000_88776655_44332211, 16'h00FF, 1'b1);
        send_word(32'h03020100, 4'hF, 1'b0);
        send_word(32'h07060504, 4'hF, 1'b0);
        send_word(32'h0B0A0908, 4'hF, 1'b0);
        send_word(32'h0F0E0D0C, 4'hF, 1'b0);
        send_word(32'h44332211, 4'hF, 1'b0);
        send_word(32'h88776655, 4'hF, 1'b1);
        wait_drain("short");
    endtask

    task automatic test_partial_keep;
        int e0 = err_seen;
        expect_beat(128'h0000BBAA, 16'h0003, 1'b1);
        send_word(32'hDDCCBBAA, 4'h3, 1'b1);
        wait_drain("partial");
        n_cmp++;
        if (err_seen != e0) begin
            n_err++; $display("FAIL partial_keep_err pulses=%0d required 0", err_seen - e0);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        logic [31:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        expect_beat({w[3], w[2], w[1], w[0]}, 16'hFFFF, 1'b0);
        expect_beat({w[7], w[6], w[5], w[4]}, 16'hFFFF, 1'b1);
        c0 = cyc;
        for (int i = 0; i < 8; i++) send_word(w[i], 4'hF, i == 7);
        n_cmp++;
        if (cyc - c0 != 8) begin
            n_err++; $display("FAIL b2b_cycles got %0d required 8", cyc - c0);
        end
        wait_drain("b2b");
    endtask

    task automatic test_backpressure;
        logic [127:0] b0;
        b0 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
        m_tready = 1'b0;
        expect_beat(b0, 16'hFFFF, 1'b0);
        expect_beat(128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, 16'hFFFF, 1'b1);
        send_word(32'hA0A0A0A0, 4'hF, 1'b0);
        send_word(32'hA1A1A1A1, 4'hF, 1'b0);
        send_word(32'hA2A2A2A2, 4'hF, 1'b0);
        send_word(32'hA3A3A3A3, 4'hF, 1'b0);
        send_word(32'hB0B0B0B0, 4'hF, 1'b0);
        send_word(32'hB1B1B1B1, 4'hF, 1'b0);
        send_word(32'hB2B2B2B2, 4'hF, 1'b0);
        s_tdata = 32'hB3B3B3B3; s_tkeep = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_cmp++;
            if (s_tready !== 1'b0) begin
                n_err++; $display("FAIL bp_s_tready got %b required 0", s_tready);
            end
            n_cmp++;
            if (m_tvalid !== 1'b1 || m_tdata !== b0 || m_tlast !== 1'b0) begin
                n_err++; $display("FAIL bp_hold got v=%b d=%h required v=1 d=%h", m_tvalid, m_tdata, b0);
            end
        end
        @(posedge aclk); #1;
        m_tready = 1'b1;
        send_word(32'hB3B3B3B3, 4'hF, 1'b1);
        @(negedge aclk);
        n_cmp++;
        if (m_tvalid !== 1'b1) begin
            n_err++; $display("FAIL bp_second_beat m_tvalid got %b required 1", m_tvalid);
        end
        wait_drain("bp");
    endtask

    task automatic test_illegal_keep;
        int e0 = err_seen;
        int p0;
        expect_beat(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_A1B2C3D4, 16'hFFFF, 1'b1);
        send_word(32'hA1B2C3D4, 4'h5, 1'b0);
        @(negedge aclk);
        n_cmp++;
        if (keep_err !== 1'b1) begin
            n_err++; $display("FAIL illegal_pulse got %b required 1", keep_err);
        end
        @(negedge aclk);
        n_cmp++;
        if (keep_err !== 1'b0) begin
            n_err++; $display("FAIL illegal_pulse_width got %b required 0", keep_err);
        end
        @(posedge aclk); #1;
        send_word(32'hC1C1C1C1, 4'hF, 1'b0);
        send_word(32'hC2C2C2C2, 4'hF, 1'b0);
        send_word(32'hC3C3C3C3, 4'hF, 1'b1);
        wait_drain("illegal_mid");

        expect_beat(128'h00220044, 16'h0005, 1'b1);
        send_word(32'h11223344, 4'h5, 1'b1);
        wait_drain("noncontig_last");

        p0 = exp_pkt;
        send_word(32'hDEADBEEF, 4'h0, 1'b1);
        @(negedge aclk);
        n_cmp++;
        if (keep_err !== 1'b1 || m_tvalid !== 1'b0) begin
            n_err++; $display("FAIL empty_last got err=%b v=%b required err=1 v=0", keep_err, m_tvalid);
        end
        wait_drain("empty_last");
        n_cmp++;
        if (exp_pkt != p0) begin
            n_err++; $display("FAIL empty_last_pkt got %0d required %0d", exp_pkt, p0);
        end

        expect_beat(128'h00000000_00000000_E2E2E2E2_E1E1E1E1, 16'h00FF, 1'b1);
        send_word(32'hE1E1E1E1, 4'hF, 1'b0);
        send_word(32'hE2E2E2E2, 4'hF, 1'b0);
        send_word(32'hDEADBEEF, 4'h0, 1'b1);
        wait_drain("zero_keep_tail");

        n_cmp++;
        if (err_seen - e0 != 3) begin
            n_err++; $display("FAIL illegal_err_count got %0d required 3", err_seen - e0);
        end
    endtask

    task automatic test_reset_mid;
        m_tready = 1'b0;
        send_word(32'h90909090, 4'hF, 1'b0);
        send_word(32'h91919191, 4'hF, 1'b0);
        send_word(32'h92929292, 4'hF, 1'b0);
        send_word(32'h93939393, 4'hF, 1'b0);
        send_word(32'h94949494, 4'hF, 1'b0);
        send_word(32'h95959595, 4'hF, 1'b0);
        #2 areset = 1'b1;
        #1;
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 || pkt_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid got v=%b d=%h k=%h p=%0d required all 0", m_tvalid, m_tdata, m_tkeep, pkt_cnt);
        end
        q.delete();
        exp_pkt = 0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        m_tready = 1'b1;
        expect_beat(128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, 16'hFFFF, 1'b1);
        send_word(32'hD0D0D0D0, 4'hF, 1'b0);
        send_word(32'hD1D1D1D1, 4'hF, 1'b0);
        send_word(32'hD2D2D2D2, 4'hF, 1'b0);
        send_word(32'hD3D3D3D3, 4'hF, 1'b1);
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_short_block();
        test_partial_keep();
        test_back_to_back();
        test_backpressure();
        test_illegal_keep();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
